// File: rtl/frame_load_ctrl.sv
// Parses 4-byte UART row packets (row, R, G, B) into frame-buffer writes and
// double-buffers the LED frame, swapping banks only at a scan frame boundary.
module frame_load_ctrl #(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned TIMEOUT_CYC = 10000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rx_valid_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     scan_frame_done_i,
  output logic                     wr_en_o,
  output logic                     wr_bank_o,
  output logic [$clog2(ROWS)-1:0]  wr_row_o,
  output logic [7:0]               wr_r_o,
  output logic [7:0]               wr_g_o,
  output logic [7:0]               wr_b_o,
  output logic                     disp_bank_o,
  output logic                     frame_swap_o,
  output logic                     hdr_err_o,
  output logic                     timeout_o,
  output logic                     overrun_o
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      RowsByte = 8'(ROWS);
  localparam logic [ROWS-1:0] MaskFull = '1;

  localparam logic [2:0] StWaitAddr = 3'd0;
  localparam logic [2:0] StGetR     = 3'd1;
  localparam logic [2:0] StGetG     = 3'd2;
  localparam logic [2:0] StGetB     = 3'd3;
  localparam logic [2:0] StPendSwap = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic [ROWS-1:0] mask_q, mask_d;
  logic            hold_vld_q, hold_vld_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            disp_bank_q, disp_bank_d;
  logic            wr_en_q, wr_en_d;
  logic            hdr_err_q, hdr_err_d;
  logic            timeout_q, timeout_d;
  logic            overrun_q, overrun_d;
  logic            frame_swap_q, frame_swap_d;

  logic            pend_like;
  logic            byte_vld;
  logic [7:0]      byte_data;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    mask_d       = mask_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    cnt_d        = cnt_q;
    disp_bank_d  = disp_bank_q;
    wr_en_d      = 1'b0;
    hdr_err_d    = 1'b0;
    timeout_d    = 1'b0;
    overrun_d    = 1'b0;
    frame_swap_d = 1'b0;
    byte_vld     = 1'b0;
    byte_data    = 8'h00;

    // The write cycle that completes a frame already behaves as PEND_SWAP for
    // incoming bytes, so nothing of the next frame is parsed before the swap.
    pend_like = (state_q == StPendSwap) || ((state_q == StWaitAddr) && (mask_q == MaskFull));

    if (pend_like) begin
      cnt_d = '0;
      if (rx_valid_i) begin
        if (hold_vld_q) begin
          overrun_d = 1'b1;
        end else begin
          hold_vld_d  = 1'b1;
          hold_data_d = rx_data_i;
        end
      end
      if (state_q == StWaitAddr) begin
        state_d = StPendSwap;
      end else if (scan_frame_done_i) begin
        disp_bank_d  = ~disp_bank_q;
        frame_swap_d = 1'b1;
        mask_d       = '0;
        state_d      = StWaitAddr;
      end
    end else begin
      // A held byte is consumed ahead of the live stream; a live byte in the
      // same cycle takes its place in the hold register.
      byte_vld  = hold_vld_q | rx_valid_i;
      byte_data = hold_vld_q ? hold_data_q : rx_data_i;
      if (hold_vld_q) begin
        hold_vld_d  = rx_valid_i;
        hold_data_d = rx_data_i;
      end

      if (byte_vld || (state_q == StWaitAddr)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end

      case (state_q)
        StWaitAddr: begin
          if (byte_vld) begin
            if (byte_data < RowsByte) begin
              row_d   = byte_data[RowW-1:0];
              state_d = StGetR;
            end else begin
              hdr_err_d = 1'b1;
            end
          end
        end
        StGetR: begin
          if (byte_vld) begin
            r_d     = byte_data;
            state_d = StGetG;
          end
        end
        StGetG: begin
          if (byte_vld) begin
            g_d     = byte_data;
            state_d = StGetB;
          end
        end
        StGetB: begin
          if (byte_vld) begin
            b_d           = byte_data;
            wr_en_d       = 1'b1;
            mask_d[row_q] = 1'b1;
            state_d       = StWaitAddr;
          end
        end
        default: state_d = StWaitAddr;
      endcase

      if (!byte_vld && (state_q != StWaitAddr) && (cnt_q == CntLast)) begin
        state_d   = StWaitAddr;
        timeout_d = 1'b1;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StWaitAddr;
      row_q        <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      mask_q       <= '0;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
      cnt_q        <= '0;
      disp_bank_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      hdr_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_swap_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      mask_q       <= mask_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      cnt_q        <= cnt_d;
      disp_bank_q  <= disp_bank_d;
      wr_en_q      <= wr_en_d;
      hdr_err_q    <= hdr_err_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      frame_swap_q <= frame_swap_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_bank_o    = ~disp_bank_q;
  assign wr_row_o     = row_q;
  assign wr_r_o       = r_q;
  assign wr_g_o       = g_q;
  assign wr_b_o       = b_q;
  assign disp_bank_o  = disp_bank_q;
  assign frame_swap_o = frame_swap_q;
  assign hdr_err_o    = hdr_err_q;
  assign timeout_o    = timeout_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Scoreboard bench for frame_load_ctrl: a packet/frame-level model predicts
// output events; a monitor pops and compares them as the DUT emits them.
module tb_frame_load_ctrl;

  localparam int unsigned TimeoutCyc = 10000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       scan;
  logic       wr_en_o, wr_bank_o, disp_bank_o, frame_swap_o, hdr_err_o, timeout_o, overrun_o;
  logic [2:0] wr_row_o;
  logic [7:0] wr_r_o, wr_g_o, wr_b_o;

  always #5 clk = ~clk;

  frame_load_ctrl #(
    .ROWS        (8),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .rx_valid_i        (rx_valid),
    .rx_data_i         (rx_data),
    .scan_frame_done_i (scan),
    .wr_en_o           (wr_en_o),
    .wr_bank_o         (wr_bank_o),
    .wr_row_o          (wr_row_o),
    .wr_r_o            (wr_r_o),
    .wr_g_o            (wr_g_o),
    .wr_b_o            (wr_b_o),
    .disp_bank_o       (disp_bank_o),
    .frame_swap_o      (frame_swap_o),
    .hdr_err_o         (hdr_err_o),
    .timeout_o         (timeout_o),
    .overrun_o         (overrun_o)
  );

  // flags = {write, hdr_err, timeout, overrun, swap}
  typedef struct packed {
    logic [4:0] flags;
    logic [2:0] row;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       bank;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model state: collected packet bytes, rows seen this frame.
  logic [7:0] pkt[$];
  logic [7:0] rows_done;
  bit         pending;
  bit         hold_v;
  logic [7:0] hold_b;
  logic       bank;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_simple(input logic [4:0] f);
    ev_t e;
    e       = '0;
    e.flags = f;
    e.bank  = bank;
    exp_q.push_back(e);
  endfunction

  function automatic bit model_byte(input logic [7:0] b);
    ev_t        e;
    logic [7:0] a;
    if (pending) begin
      if (hold_v) push_simple(5'b00010);
      else begin
        hold_v = 1'b1;
        hold_b = b;
      end
      return 1'b0;
    end
    if (pkt.size() == 0 && b > 8'd7) begin
      push_simple(5'b01000);
      return 1'b0;
    end
    pkt.push_back(b);
    if (pkt.size() == 4) begin
      a       = pkt[0];
      e.flags = 5'b10000;
      e.row   = a[2:0];
      e.r     = pkt[1];
      e.g     = pkt[2];
      e.b     = pkt[3];
      e.bank  = ~bank;
      exp_q.push_back(e);
      rows_done[a[2:0]] = 1'b1;
      pkt.delete();
      if (rows_done == 8'hFF) pending = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_scan();
    if (!pending) return;
    bank      = ~bank;
    push_simple(5'b00001);
    rows_done = '0;
    pending   = 1'b0;
    if (hold_v) begin
      hold_v = 1'b0;
      void'(model_byte(hold_b));
    end
  endfunction

  function automatic void model_reset();
    pkt.delete();
    rows_done = '0;
    pending   = 1'b0;
    hold_v    = 1'b0;
    hold_b    = '0;
    bank      = 1'b0;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    bit w;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    w        = model_byte(b);
    @(negedge clk);
    rx_valid = 1'b0;
    check("wr_en_latency", {31'd0, wr_en_o}, {31'd0, w});
    repeat (gap) @(negedge clk);
  endtask

  task automatic packet(input logic [7:0] row, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
    send(row, 2);
    send(r, 2);
    send(g, 2);
    send(b, 3);
  endtask

  task automatic pulse_scan();
    @(negedge clk);
    scan = 1'b1;
    model_scan();
    @(negedge clk);
    scan = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic byte_and_scan(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    scan     = 1'b1;
    void'(model_byte(b));
    model_scan();
    @(negedge clk);
    rx_valid = 1'b0;
    scan     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every cycle with an output pulse must match the next predicted event.
  always @(negedge clk) begin
    logic [4:0] f;
    ev_t        act, exp;
    f = {wr_en_o, hdr_err_o, timeout_o, overrun_o, frame_swap_o};
    if (rst_n && f != 5'd0) begin
      act       = '0;
      act.flags = f;
      if (wr_en_o) begin
        act.row  = wr_row_o;
        act.r    = wr_r_o;
        act.g    = wr_g_o;
        act.b    = wr_b_o;
        act.bank = wr_bank_o;
      end else begin
        act.bank = disp_bank_o;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got flags=%b with nothing predicted", f);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL event: got flags=%b row=%0d rgb=%h/%h/%h bank=%0d expected flags=%b row=%0d rgb=%h/%h/%h bank=%0d",
                   act.flags, act.row, act.r, act.g, act.b, act.bank,
                   exp.flags, exp.row, exp.r, exp.g, exp.b, exp.bank);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    int  act_cnt;
    logic [7:0] rr;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    scan     = 1'b0;
    model_reset();
    #1;
    check("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    check("rst_disp_bank", {31'd0, disp_bank_o}, 32'd0);
    check("rst_wr_bank", {31'd0, wr_bank_o}, 32'd1);
    check("rst_pulses", {27'd0, frame_swap_o, hdr_err_o, timeout_o, overrun_o, wr_en_o}, 32'd0);
    check("rst_wr_data", {5'd0, wr_row_o, wr_r_o, wr_g_o, wr_b_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame rows 0..7, then swap.
    for (int i = 0; i < 8; i++) packet(8'(i), 8'hFF, 8'h00, 8'hFF);
    pulse_scan();
    check("bank_after_first_swap", {31'd0, disp_bank_o}, {31'd0, bank});

    // Bad header, then a good row-2 packet.
    send(8'h09, 3);
    packet(8'h02, 8'h12, 8'h34, 8'h56);

    // Partial packet timeout.
    send(8'h03, 2);
    send(8'hAA, 0);
    model_timeout_push: begin
      if (pkt.size() != 0) begin
        push_simple(5'b00100);
        pkt.delete();
      end
    end
    seen = 0;
    act_cnt = 0;
    while (seen == 0 && act_cnt < TimeoutCyc + 20) begin
      @(negedge clk);
      act_cnt++;
      if (timeout_o) seen = act_cnt;
    end
    check("timeout_idle_cycles", seen, TimeoutCyc);
    repeat (3) @(negedge clk);
    packet(8'h03, 8'h11, 8'h22, 8'h33);

    // Complete the frame; bytes while waiting for scan go to hold / overrun.
    packet(8'h00, 8'h01, 8'h02, 8'h03);
    packet(8'h01, 8'h04, 8'h05, 8'h06);
    for (int i = 4; i < 8; i++) packet(8'(i), 8'(i * 3), 8'(i * 5), 8'(i * 7));
    send(8'h05, 3);
    send(8'h66, 3);
    repeat (5) @(negedge clk);
    check("no_swap_before_scan", {31'd0, disp_bank_o}, 32'd1);
    pulse_scan();
    check("bank_after_second_swap", {31'd0, disp_bank_o}, {31'd0, bank});
    send(8'h77, 2);
    send(8'h88, 2);
    send(8'h99, 3);

    // Duplicate row 4; stray scan pulse before the frame is complete.
    packet(8'h04, 8'hA1, 8'hA2, 8'hA3);
    for (int i = 0; i < 4; i++) packet(8'(i), 8'h10, 8'h20, 8'h30);
    packet(8'h05, 8'h50, 8'h51, 8'h52);
    packet(8'h04, 8'hB1, 8'hB2, 8'hB3);
    packet(8'h06, 8'h60, 8'h61, 8'h62);
    pulse_scan();
    check("stray_scan_ignored", {31'd0, disp_bank_o}, 32'd0);
    packet(8'h07, 8'h70, 8'h71, 8'h72);
    byte_and_scan(8'h06);
    check("bank_after_third_swap", {31'd0, disp_bank_o}, {31'd0, bank});
    send(8'h11, 2);
    send(8'h22, 2);
    send(8'h33, 3);

    // Reset in GET_G while displaying bank 1.
    send(8'h01, 2);
    send(8'h12, 2);
    check("bank_before_reset", {31'd0, disp_bank_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_disp_bank", {31'd0, disp_bank_o}, 32'd0);
    check("midrst_outputs", {26'd0, frame_swap_o, hdr_err_o, timeout_o, overrun_o, wr_en_o,
                             wr_bank_o}, 32'd1);
    check("midrst_scoreboard_empty", exp_q.size(), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    packet(8'h02, 8'hAB, 8'hCD, 8'hEF);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      act_cnt = int'($urandom_range(0, 9));
      if (act_cnt == 0) begin
        rr = 8'($urandom_range(8, 255));
        send(rr, int'($urandom_range(2, 8)));
      end else if (act_cnt == 1) begin
        pulse_scan();
      end else begin
        send(8'($urandom_range(0, 7)), int'($urandom_range(2, 8)));
        send(8'($urandom), int'($urandom_range(2, 8)));
        send(8'($urandom), int'($urandom_range(2, 8)));
        send(8'($urandom), int'($urandom_range(3, 8)));
      end
    end

    repeat (50) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
